// File: rtl/periodic_count_ctrl.sv
// Periodic event counter: counts completed tick periods inside a
// tick window, with abort, saturation and one-cycle done pulse.
module periodic_count_ctrl #(
  parameter int CW = 8,
  parameter int PW = 4
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          tick,
  input  logic          start,
  input  logic          abort,
  input  logic [PW-1:0] period,
  input  logic [7:0]    window,
  output logic [CW-1:0] count,
  output logic          evt,
  output logic          busy,
  output logic          done,
  output logic          aborted
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALT
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] per_q, per_d;
  logic [7:0]    win_q, win_d;
  logic [PW-1:0] ph_q, ph_d;
  logic [7:0]    wt_q, wt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          evt_q, evt_d;
  logic          ab_q, ab_d;

  // State and datapath registers; reset forces period 1, unlimited window
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      per_q   <= PW'(1);
      win_q   <= '0;
      ph_q    <= '0;
      wt_q    <= '0;
      cnt_q   <= '0;
      evt_q   <= 1'b0;
      ab_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      per_q   <= per_d;
      win_q   <= win_d;
      ph_q    <= ph_d;
      wt_q    <= wt_d;
      cnt_q   <= cnt_d;
      evt_q   <= evt_d;
      ab_q    <= ab_d;
    end
  end

  // Next-state: launch, tick accounting, abort and window stop
  always_comb begin
    state_d = state_q;
    per_d   = per_q;
    win_d   = win_q;
    ph_d    = ph_q;
    wt_d    = wt_q;
    cnt_d   = cnt_q;
    evt_d   = 1'b0;
    ab_d    = ab_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          per_d   = (period == '0) ? PW'(1) : period;
          win_d   = window;
          ph_d    = '0;
          wt_d    = '0;
          cnt_d   = '0;
          ab_d    = 1'b0;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = HALT;
          ab_d    = 1'b1;
        end else if (tick) begin
          if (ph_q == per_q - PW'(1)) begin
            ph_d  = '0;
            evt_d = 1'b1;
            if (cnt_q != '1) cnt_d = cnt_q + CW'(1);
          end else begin
            ph_d = ph_q + PW'(1);
          end
          if (wt_q != 8'hFF) wt_d = wt_q + 8'd1;
          if (win_q != 8'd0 && wt_d == win_q) state_d = HALT;
        end
      end
      HALT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign count   = cnt_q;
  assign evt     = evt_q;
  assign busy    = (state_q != IDLE);
  assign done    = (state_q == HALT);
  assign aborted = ab_q;

endmodule

// File: tb/tb_periodic_count_ctrl.sv
// Directed bench for periodic_count_ctrl: vector table plus
// sequences for saturation and asynchronous reset.
module tb_periodic_count_ctrl;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       tick, start, abort;
  logic [3:0] period;
  logic [7:0] window;
  logic [7:0] count;
  logic       evt, busy, done, aborted;
  logic [1:0] count2;
  logic       evt2, busy2, done2, aborted2;

  int nvec = 0;
  int nerr = 0;
  int nevt2;

  always #5 clock = ~clock;

  periodic_count_ctrl #(.CW(8), .PW(4)) dut (
    .clock(clock), .reset_n(reset_n), .tick(tick),
    .start(start), .abort(abort), .period(period),
    .window(window), .count(count), .evt(evt),
    .busy(busy), .done(done), .aborted(aborted)
  );

  periodic_count_ctrl #(.CW(2), .PW(4)) dut2 (
    .clock(clock), .reset_n(reset_n), .tick(tick),
    .start(start), .abort(abort), .period(period),
    .window(window), .count(count2), .evt(evt2),
    .busy(busy2), .done(done2), .aborted(aborted2)
  );

  typedef struct {
    string      nm;
    logic       s, a, t;
    logic [3:0] p;
    logic [7:0] w;
    logic [7:0] c;
    logic       e, b, d, ab;
  } vec_t;

  vec_t vq[$];

  function automatic void add(string nm, logic s, logic a, logic t,
                              logic [3:0] p, logic [7:0] w,
                              logic [7:0] c, logic e, logic b,
                              logic d, logic ab);
    vec_t v;
    v.nm = nm; v.s = s; v.a = a; v.t = t; v.p = p; v.w = w;
    v.c = c; v.e = e; v.b = b; v.d = d; v.ab = ab;
    vq.push_back(v);
  endfunction

  task automatic check(string nm, logic [7:0] c, logic e,
                       logic b, logic d, logic ab);
    logic [1:0] c2;
    c2 = (c > 8'd3) ? 2'd3 : c[1:0];
    nvec++;
    if (count !== c || evt !== e || busy !== b || done !== d ||
        aborted !== ab || count2 !== c2 || evt2 !== e ||
        busy2 !== b || done2 !== d || aborted2 !== ab) begin
      nerr++;
      $display("FAIL %s: got c=%0d e=%b b=%b d=%b ab=%b c2=%0d e2=%b b2=%b d2=%b ab2=%b exp c=%0d e=%b b=%b d=%b ab=%b c2=%0d",
               nm, count, evt, busy, done, aborted, count2, evt2,
               busy2, done2, aborted2, c, e, b, d, ab, c2);
    end
  endtask

  task automatic step(logic s, logic a, logic t,
                      logic [3:0] p, logic [7:0] w);
    start = s; abort = a; tick = t; period = p; window = w;
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    tick = 0; start = 0; abort = 0; period = 0; window = 0;

    // abort after 5 ticks, period 2, unlimited window
    add("a_start", 1,0,0, 2,0,   0,0,1,0,0);
    add("a_t1",    0,0,1, 2,0,   0,0,1,0,0);
    add("a_g1",    0,0,0, 2,0,   0,0,1,0,0);
    add("a_t2",    0,0,1, 2,0,   1,1,1,0,0);
    add("a_g2",    0,0,0, 2,0,   1,0,1,0,0);
    add("a_t3",    0,0,1, 2,0,   1,0,1,0,0);
    add("a_g3",    0,0,0, 2,0,   1,0,1,0,0);
    add("a_t4",    0,0,1, 2,0,   2,1,1,0,0);
    add("a_g4",    0,0,0, 2,0,   2,0,1,0,0);
    add("a_t5",    0,0,1, 2,0,   2,0,1,0,0);
    add("a_abort", 0,1,0, 2,0,   2,0,1,1,1);
    add("a_x1",    0,0,1, 2,0,   2,0,0,0,1);
    add("a_x2",    0,1,0, 2,0,   2,0,0,0,1);
    add("a_x3",    0,0,1, 2,0,   2,0,0,0,1);
    add("a_x4",    0,0,1, 2,0,   2,0,0,0,1);
    // period 3, window 7, tick every cycle
    add("w_start", 1,0,1, 3,7,   0,0,1,0,0);
    add("w_t1",    0,0,1, 3,7,   0,0,1,0,0);
    add("w_t2",    0,0,1, 3,7,   0,0,1,0,0);
    add("w_t3",    0,0,1, 3,7,   1,1,1,0,0);
    add("w_t4",    0,0,1, 3,7,   1,0,1,0,0);
    add("w_t5",    0,0,1, 3,7,   1,0,1,0,0);
    add("w_t6",    0,0,1, 3,7,   2,1,1,0,0);
    add("w_t7",    0,0,1, 3,7,   2,0,1,1,0);
    add("w_idle",  0,0,1, 3,7,   2,0,0,0,0);
    // period 2, window 4: last tick completes period and stops
    add("b_start", 1,0,0, 2,4,   0,0,1,0,0);
    add("b_t1",    0,0,1, 2,4,   0,0,1,0,0);
    add("b_t2",    0,0,1, 2,4,   1,1,1,0,0);
    add("b_t3",    0,0,1, 2,4,   1,0,1,0,0);
    add("b_t4",    0,0,1, 2,4,   2,1,1,1,0);
    add("b_idle",  0,0,1, 2,4,   2,0,0,0,0);
    add("b_idle2", 0,0,0, 2,4,   2,0,0,0,0);
    // start+abort in idle, then abort with period-completing tick
    add("c_start", 1,1,0, 2,0,   0,0,1,0,0);
    add("c_t1",    0,0,1, 2,0,   0,0,1,0,0);
    add("c_abtk",  0,1,1, 2,0,   0,0,1,1,1);
    add("c_idle",  0,0,1, 2,0,   0,0,0,0,1);
    // period 0 acts as 1; start in RUN ignored
    add("p_start", 1,0,0, 0,3,   0,0,1,0,0);
    add("p_t1",    1,0,1, 2,0,   1,1,1,0,0);
    add("p_t2",    0,0,1, 2,0,   2,1,1,0,0);
    add("p_t3",    0,0,1, 2,0,   3,1,1,1,0);
    add("p_idle",  0,0,0, 2,0,   3,0,0,0,0);

    #2;
    check("reset", 0,0,0,0,0);
    #10;
    reset_n = 1'b1;

    foreach (vq[i]) begin
      step(vq[i].s, vq[i].a, vq[i].t, vq[i].p, vq[i].w);
      check(vq[i].nm, vq[i].c, vq[i].e, vq[i].b, vq[i].d, vq[i].ab);
    end

    // narrow counter saturates while evt keeps pulsing
    nevt2 = 0;
    step(1,0,0, 1,0);
    check("s_start", 0,0,1,0,0);
    for (int i = 1; i <= 5; i++) begin
      step(0,0,1, 1,0);
      nevt2 += int'(evt2);
      check("s_tick", 8'(i),1,1,0,0);
    end
    nvec++;
    if (nevt2 != 5) begin
      nerr++;
      $display("FAIL s_evtcnt: got %0d pulses, exp 5", nevt2);
    end
    step(0,1,0, 1,0);
    check("s_abort", 5,0,1,1,1);
    step(0,0,0, 1,0);
    check("s_idle", 5,0,0,0,1);

    // asynchronous reset in the middle of a run
    step(1,0,0, 1,0);
    check("r_start", 0,0,1,0,0);
    step(0,0,1, 1,0);
    step(0,0,1, 1,0);
    step(0,0,1, 1,0);
    check("r_c3", 3,1,1,0,0);
    #2;
    reset_n = 1'b0;
    #1;
    check("r_async", 0,0,0,0,0);
    #3;
    reset_n = 1'b1;
    step(0,0,1, 1,0);
    check("r_rel", 0,0,0,0,0);
    step(1,0,0, 2,0);
    check("r_start2", 0,0,1,0,0);
    step(0,0,1, 2,0);
    check("r_t1", 0,0,1,0,0);
    step(0,0,1, 2,0);
    check("r_t2", 1,1,1,0,0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
